// File: rtl/sia_rx_ctl_if.sv
// Wishbone B4 classic bus bundle used by sia_rx_ctl.
// Signal suffixes are seen from the slave side.
interface sia_rx_ctl_if;
    logic        cyc_i;
    logic        stb_i;
    logic        we_i;
    logic [2:0]  adr_i;
    logic [15:0] dat_i;
    logic [15:0] dat_o;
    logic        ack_o;

    modport master (output cyc_i, stb_i, we_i, adr_i, dat_i, input dat_o, ack_o);
    modport slave  (input cyc_i, stb_i, we_i, adr_i, dat_i, output dat_o, ack_o);
endinterface

// File: rtl/sia_rx_ctl.sv
// SIA receive-path controller: Wishbone register file plus receive-queue drain sequencer.
// Optional interrupt logic is built only when SIA_RXC_IRQ_EN is defined.
module sia_rx_ctl #(
    parameter int          SHIFT_REG_WIDTH = 16,
    parameter int          BAUD_RATE_WIDTH = 32,
    parameter int          RESET_BITS      = 10,
    parameter logic [31:0] RESET_BAUD      = 32'd0
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    sia_rx_ctl_if.slave                wb,
    output logic [5:0]                 bits_o,
    output logic [BAUD_RATE_WIDTH-1:0] baud_o,
    output logic                       eedd_o,
    output logic                       eedc_o,
    input  logic [SHIFT_REG_WIDTH-1:0] rxq_dat_i,
    input  logic                       rxq_full_i,
    input  logic                       rxq_not_empty_i,
    output logic                       rxq_oe_o,
    output logic                       rxq_pop_o,
    output logic                       irq_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OE   = 2'd1;
    localparam logic [1:0] ST_POP  = 2'd2;
    localparam logic [1:0] ST_ACK  = 2'd3;

    localparam logic [2:0] A_STATUS  = 3'd0;
    localparam logic [2:0] A_CONFIG  = 3'd1;
    localparam logic [2:0] A_BAUD_LO = 3'd2;
    localparam logic [2:0] A_BAUD_HI = 3'd3;
    localparam logic [2:0] A_DATA    = 3'd4;

    logic [1:0]  state;
    logic [15:0] rdat;
    logic [15:0] staging;
    logic [15:0] rd_mux;
    logic        ovf;
    logic        full_q;
    logic        ie;
    logic        req;
    logic        wr_req;
    logic        pop_req;
    logic        full_rise;
    logic        ovf_clr;

    // Strobes are only accepted in IDLE, which spaces back-to-back accesses.
    assign req       = (state == ST_IDLE) & wb.cyc_i & wb.stb_i;
    assign wr_req    = req & wb.we_i;
    assign pop_req   = req & ~wb.we_i & (wb.adr_i == A_DATA) & rxq_not_empty_i;
    assign full_rise = rxq_full_i & ~full_q;
    assign ovf_clr   = wr_req & (wb.adr_i == A_STATUS) & wb.dat_i[2];

    always_comb begin
        rd_mux = '0;
        case (wb.adr_i)
            A_STATUS:  rd_mux = {13'd0, ovf, rxq_full_i, rxq_not_empty_i};
            A_CONFIG:  rd_mux = {7'd0, ie, eedc_o, eedd_o, bits_o};
            A_BAUD_LO: rd_mux = staging;
            A_BAUD_HI: rd_mux = 16'(baud_o >> 16);
            default:   rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (req) state <= pop_req ? ST_OE : ST_ACK;
                ST_OE:   state <= wb.cyc_i ? ST_POP : ST_IDLE;
                ST_POP:  state <= ST_ACK;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Register reads latch at the sample edge; a DATA pop overwrites on POP exit.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rdat <= '0;
        end else if (req & ~wb.we_i) begin
            rdat <= rd_mux;
        end else if (state == ST_POP) begin
            rdat <= 16'(rxq_dat_i);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            bits_o  <= 6'(RESET_BITS);
            baud_o  <= BAUD_RATE_WIDTH'(RESET_BAUD);
            eedd_o  <= 1'b0;
            eedc_o  <= 1'b0;
            staging <= '0;
        end else if (wr_req) begin
            case (wb.adr_i)
                A_CONFIG:  {eedc_o, eedd_o, bits_o} <= wb.dat_i[7:0];
                A_BAUD_LO: staging <= wb.dat_i;
                A_BAUD_HI: baud_o <= BAUD_RATE_WIDTH'({wb.dat_i, staging});
                default:   ;
            endcase
        end
    end

    // A fresh rising edge of full beats a simultaneous software clear.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            full_q <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            full_q <= rxq_full_i;
            if (full_rise)
                ovf <= 1'b1;
            else if (ovf_clr)
                ovf <= 1'b0;
        end
    end

`ifdef SIA_RXC_IRQ_EN
    logic irq_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ie    <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            if (wr_req && (wb.adr_i == A_CONFIG))
                ie <= wb.dat_i[8];
            irq_q <= ie & (rxq_not_empty_i | ovf);
        end
    end

    assign irq_o = irq_q;
`else
    assign ie    = 1'b0;
    assign irq_o = 1'b0;
`endif

    assign rxq_oe_o  = (state == ST_OE) | (state == ST_POP);
    assign rxq_pop_o = (state == ST_POP);
    assign wb.ack_o  = (state == ST_ACK) & wb.cyc_i;
    assign wb.dat_o  = wb.ack_o ? rdat : '0;

endmodule

// File: tb/tb_sia_rx_ctl.sv
// Self-checking bench for sia_rx_ctl: directed table, corner-case sequences and
// randomized traffic against a transaction-level register/queue model.
module tb_sia_rx_ctl;
`ifdef SIA_RXC_IRQ_EN
    localparam bit HAS_IRQ = 1'b1;
`else
    localparam bit HAS_IRQ = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_i;
    logic [5:0]  bits_o;
    logic [31:0] baud_o;
    logic        eedd_o, eedc_o;
    logic [15:0] rxq_dat;
    logic        rxq_full;
    logic        rxq_not_empty;
    logic        rxq_oe, rxq_pop, irq_o;

    always #5 clk = ~clk;

    sia_rx_ctl_if bus();

    sia_rx_ctl dut (
        .clk_i          (clk),
        .reset_i        (reset_i),
        .wb             (bus),
        .bits_o         (bits_o),
        .baud_o         (baud_o),
        .eedd_o         (eedd_o),
        .eedc_o         (eedc_o),
        .rxq_dat_i      (rxq_dat),
        .rxq_full_i     (rxq_full),
        .rxq_not_empty_i(rxq_not_empty),
        .rxq_oe_o       (rxq_oe),
        .rxq_pop_o      (rxq_pop),
        .irq_o          (irq_o)
    );

    // Receive-queue stand-in: words pushed by the stimulus, popped by the DUT.
    logic [15:0] qmem [0:15];
    logic [7:0]  wr_ptr = 8'd0;
    logic [7:0]  rd_ptr = 8'd0;
    assign rxq_not_empty = (wr_ptr != rd_ptr);
    assign rxq_dat       = qmem[rd_ptr[3:0]];
    always @(posedge clk) if (rxq_pop) rd_ptr <= rd_ptr + 8'd1;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [5:0]  m_bits;
    logic [31:0] m_baud;
    logic [15:0] m_stage;
    bit          m_ovf, m_ie, m_eedd, m_eedc, m_full;
    logic [15:0] exp_q [$];

    typedef struct {
        bit          we;
        logic [2:0]  adr;
        logic [15:0] wd;
        logic [15:0] er;
        int          lat;
    } vec_t;
    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_bits = 6'd10; m_baud = 32'd0; m_stage = 16'd0;
        m_ovf = 1'b0; m_ie = 1'b0; m_eedd = 1'b0; m_eedc = 1'b0;
    endtask

    task automatic model_access(input bit we, input logic [2:0] adr, input logic [15:0] wd,
                                input bit raise, output logic [15:0] er,
                                output int elat, output int epop);
        er = 16'd0; elat = 1; epop = 0;
        if (we) begin
            case (adr)
                3'd0: if (wd[2]) m_ovf = 1'b0;
                3'd1: begin
                    m_bits = wd[5:0]; m_eedd = wd[6]; m_eedc = wd[7];
                    if (HAS_IRQ) m_ie = wd[8];
                end
                3'd2: m_stage = wd;
                3'd3: m_baud = {wd, m_stage};
                default: ;
            endcase
        end else begin
            case (adr)
                3'd0: er = {13'd0, m_ovf, m_full, (exp_q.size() != 0)};
                3'd1: er = {7'd0, m_ie, m_eedc, m_eedd, m_bits};
                3'd2: er = m_stage;
                3'd3: er = m_baud[31:16];
                3'd4: if (exp_q.size() != 0) begin
                    er = exp_q.pop_front(); elat = 3; epop = 1;
                end
                default: ;
            endcase
        end
        if (raise) begin
            if (!m_full) m_ovf = 1'b1;
            m_full = 1'b1;
        end
    endtask

    task automatic wb_access(input bit we, input logic [2:0] adr, input logic [15:0] wd,
                             input bit raise, output logic [15:0] rd,
                             output int lat, output int pops, output int oes);
        bit got = 1'b0;
        @(negedge clk);
        bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = we; bus.adr_i = adr; bus.dat_i = wd;
        if (raise) rxq_full = 1'b1;
        @(posedge clk);
        lat = 0; pops = 0; oes = 0; rd = 16'd0;
        for (int i = 1; i <= 20 && !got; i++) begin
            #1;
            if (rxq_pop) pops++;
            if (rxq_oe) oes++;
            if (bus.ack_o) begin
                got = 1'b1; lat = i; rd = bus.dat_o;
            end else begin
                @(posedge clk);
            end
        end
        if (!got) begin
            checks++; failures++;
            $display("FAIL ack_timeout actual=no_ack required=ack adr=%0d", adr);
        end
        @(negedge clk);
        bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.we_i = 1'b0;
    endtask

    task automatic do_op(input bit we, input logic [2:0] adr, input logic [15:0] wd,
                         input bit raise, input string name);
        logic [15:0] er, rd;
        int elat, epop, lat, pops, oes;
        model_access(we, adr, wd, raise, er, elat, epop);
        wb_access(we, adr, wd, raise, rd, lat, pops, oes);
        if (!we) chk({name, "_rdata"}, rd, er);
        chk({name, "_latency"}, lat, elat);
        chk({name, "_pops"}, pops, epop);
        chk({name, "_oe_cycles"}, oes, epop * 2);
        chk({name, "_cfg"}, {bits_o, eedd_o, eedc_o}, {m_bits, m_eedd, m_eedc});
        chk({name, "_baud"}, baud_o, m_baud);
    endtask

    task automatic push(input logic [15:0] w);
        @(negedge clk);
        qmem[wr_ptr[3:0]] = w;
        wr_ptr = wr_ptr + 8'd1;
        exp_q.push_back(w);
    endtask

    task automatic set_full(input bit v);
        @(negedge clk);
        if (v && !m_full) m_ovf = 1'b1;
        m_full = v;
        rxq_full = v;
    endtask

    task automatic chk_irq(input string name);
        repeat (2) @(posedge clk);
        #1;
        chk(name, irq_o, HAS_IRQ & m_ie & ((exp_q.size() != 0) | m_ovf));
    endtask

    initial begin
        logic [15:0] rd, er;
        int lat, pops, oes, elat, epop, cnt_pop, cnt_ack;

        for (int i = 0; i < 16; i++) qmem[i] = 16'h0;
        reset_i = 1'b1; rxq_full = 1'b0; m_full = 1'b0;
        bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.we_i = 1'b0; bus.adr_i = 3'd0; bus.dat_i = 16'd0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk); reset_i = 1'b0;
        #1;
        chk("rst_strobes", {bus.ack_o, rxq_oe, rxq_pop, irq_o}, 4'b0000);
        chk("rst_dat_o", bus.dat_o, 16'h0);
        chk("rst_bits", bits_o, 6'd10);
        chk("rst_baud", baud_o, 32'h0);
        chk("rst_edges", {eedd_o, eedc_o}, 2'b00);

        tbl[0]  = '{1'b0, 3'd1, 16'h0000, 16'h000A, 1};
        tbl[1]  = '{1'b0, 3'd3, 16'h0000, 16'h0000, 1};
        tbl[2]  = '{1'b0, 3'd2, 16'h0000, 16'h0000, 1};
        tbl[3]  = '{1'b0, 3'd0, 16'h0000, 16'h0000, 1};
        tbl[4]  = '{1'b0, 3'd4, 16'h0000, 16'h0000, 1};
        tbl[5]  = '{1'b0, 3'd5, 16'h0000, 16'h0000, 1};
        tbl[6]  = '{1'b1, 3'd1, 16'hFFC5, 16'h0000, 1};
        tbl[7]  = '{1'b0, 3'd1, 16'h0000, HAS_IRQ ? 16'h01C5 : 16'h00C5, 1};
        tbl[8]  = '{1'b1, 3'd7, 16'hFFFF, 16'h0000, 1};
        tbl[9]  = '{1'b0, 3'd7, 16'h0000, 16'h0000, 1};
        tbl[10] = '{1'b1, 3'd1, 16'h000A, 16'h0000, 1};
        tbl[11] = '{1'b0, 3'd1, 16'h0000, 16'h000A, 1};
        for (int i = 0; i < 12; i++) begin
            model_access(tbl[i].we, tbl[i].adr, tbl[i].wd, 1'b0, er, elat, epop);
            wb_access(tbl[i].we, tbl[i].adr, tbl[i].wd, 1'b0, rd, lat, pops, oes);
            if (!tbl[i].we) chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].er);
            chk($sformatf("tbl%0d_latency", i), lat, tbl[i].lat);
            chk($sformatf("tbl%0d_pops", i), pops, 0);
            if (i == 7) chk("tbl_edges_on", {eedd_o, eedc_o}, 2'b11);
        end
        chk("edges_off", {eedd_o, eedc_o}, 2'b00);

        // Baud staging and commit
        do_op(1'b1, 3'd2, 16'h1234, 1'b0, "baud_lo_wr");
        chk("baud_unchanged", baud_o, 32'h0);
        do_op(1'b1, 3'd3, 16'h0001, 1'b0, "baud_hi_wr");
        chk("baud_commit", baud_o, 32'h0001_1234);
        do_op(1'b0, 3'd3, 16'h0, 1'b0, "baud_hi_rd");
        do_op(1'b0, 3'd2, 16'h0, 1'b0, "baud_lo_rd");

        // Queue drain
        push(16'h00A5); push(16'h005A);
        do_op(1'b0, 3'd4, 16'h0, 1'b0, "data_rd1");
        do_op(1'b0, 3'd4, 16'h0, 1'b0, "data_rd2");
        do_op(1'b0, 3'd4, 16'h0, 1'b0, "data_empty");
        do_op(1'b1, 3'd4, 16'hBEEF, 1'b0, "data_wr_ignored");

        // Overflow sticky bit
        push(16'h0011);
        set_full(1'b1);
        do_op(1'b0, 3'd0, 16'h0, 1'b0, "status_ovf");
        chk("status_ovf_literal", {13'd0, m_ovf, m_full, 1'b1}, 16'h0007);
        do_op(1'b1, 3'd0, 16'h0004, 1'b0, "ovf_clear");
        do_op(1'b0, 3'd0, 16'h0, 1'b0, "status_cleared");
        set_full(1'b0);
        do_op(1'b1, 3'd0, 16'h0004, 1'b1, "ovf_clr_and_set");
        do_op(1'b0, 3'd0, 16'h0, 1'b0, "status_set_wins");
        set_full(1'b0);
        do_op(1'b1, 3'd0, 16'h0004, 1'b0, "ovf_clear2");
        do_op(1'b0, 3'd4, 16'h0, 1'b0, "drain_0011");

        // Interrupt
        do_op(1'b1, 3'd1, 16'h010A, 1'b0, "ie_wr");
        chk_irq("irq_idle");
        push(16'h0077);
        #1 chk("irq_before_edge", irq_o, 1'b0);
        @(posedge clk); #1;
        chk("irq_rise", irq_o, HAS_IRQ);
        do_op(1'b0, 3'd4, 16'h0, 1'b0, "irq_drain");
        chk_irq("irq_fall");

        // Abandon during OE: no pop, no ack
        push(16'h0033);
        @(negedge clk);
        bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = 1'b0; bus.adr_i = 3'd4;
        @(posedge clk); #1;
        chk("abort_oe_active", rxq_oe, 1'b1);
        @(negedge clk); bus.cyc_i = 1'b0; bus.stb_i = 1'b0;
        cnt_pop = 0; cnt_ack = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (rxq_pop) cnt_pop++;
            if (bus.ack_o) cnt_ack++;
        end
        chk("abort_oe_pops", cnt_pop, 0);
        chk("abort_oe_acks", cnt_ack, 0);
        chk("abort_oe_word_kept", {rxq_not_empty, rxq_dat}, {1'b1, 16'h0033});

        // Abandon during POP: pop completes, word discarded, no ack
        @(negedge clk);
        bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.adr_i = 3'd4;
        @(posedge clk);
        @(posedge clk); #1;
        chk("abort_pop_strobe", rxq_pop, 1'b1);
        @(negedge clk); bus.cyc_i = 1'b0; bus.stb_i = 1'b0;
        @(posedge clk); #1;
        chk("abort_pop_ack", {bus.ack_o, bus.dat_o}, 17'h0);
        chk("abort_pop_pop_done", rxq_not_empty, 1'b0);
        void'(exp_q.pop_front());

        // Asynchronous reset mid-access
        push(16'h0044);
        @(negedge clk);
        bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.adr_i = 3'd4;
        @(posedge clk); #2;
        reset_i = 1'b1;
        #1;
        chk("rst_mid_strobes", {rxq_oe, rxq_pop, bus.ack_o}, 3'b000);
        chk("rst_mid_cfg", {bits_o, baud_o}, {6'd10, 32'h0});
        @(negedge clk); bus.cyc_i = 1'b0; bus.stb_i = 1'b0;
        @(negedge clk); reset_i = 1'b0;
        model_reset();
        #1 chk("rst_mid_no_pop", {rxq_not_empty, rxq_dat}, {1'b1, 16'h0044});
        do_op(1'b0, 3'd4, 16'h0, 1'b0, "post_rst_data");

        // Randomized traffic
        for (int n = 0; n < 200; n++) begin
            int sel;
            sel = $urandom_range(0, 9);
            if (sel <= 1) begin
                if (exp_q.size() < 12) push(16'($urandom));
            end else if (sel == 2) begin
                set_full(~m_full);
            end else begin
                bit          we;
                logic [2:0]  adr;
                logic [15:0] wd;
                we  = 1'($urandom_range(0, 1));
                adr = 3'($urandom_range(0, 7));
                wd  = 16'($urandom);
                do_op(we, adr, wd, 1'b0, $sformatf("rnd%0d", n));
            end
            if (n % 8 == 0) chk_irq($sformatf("rnd%0d_irq", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
